// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter.
// Frame layout: start bit (0), DATA_W data bits LSB first, optional parity bit,
// then STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT enabled clocks.
//
// Handshake: a word is accepted on a rising clk edge when tx_valid, tx_ready
// and en are all high. tx_ready is high only in IDLE with en high; tx_valid
// and tx_data are don't-care at every other time (no queuing).
//
// en low freezes every register, so bit timing resumes exactly where it
// stopped. tx_ready and done are masked by en so that no handshake is offered
// and no completion is reported while frozen.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_tx_param: illegal parameter value");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // done is registered, so it is set on the edge entering the final cycle
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // State register and all registered outputs; reset forces an idle line.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; everything holds while en is low.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      if (state_q != S_IDLE) begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_valid && ready_q) begin
            shift_d = tx_data;
            // parity is frozen from the accepted word, not from live tx_data
            par_d   = (^tx_data) ^ ODD_PAR;
            state_d = S_START;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
          end
        end
        S_START: begin
          if (baud_last) begin
            state_d = S_DATA;
            txd_d   = shift_q[0];
          end
        end
        S_DATA: begin
          if (baud_last) begin
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            if (bit_q == DATA_LAST) begin
              bit_d = '0;
              if (PARITY != 0) begin
                state_d = S_PARITY;
                txd_d   = par_q;
              end else begin
                state_d = S_STOP;
                txd_d   = 1'b1;
              end
            end else begin
              bit_d = bit_q + 4'd1;
              txd_d = shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
            bit_d   = '0;
          end
        end
        S_STOP: begin
          done_d = (bit_q == STOP_LAST) && (baud_q == BAUD_PRE);
          if (baud_last) begin
            if (bit_q == STOP_LAST) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              ready_d = 1'b1;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q & en;
  assign done     = done_q & en;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param. Four instances cover 8N1, 8E1, 8O1 and
// 5N2 at CLKS_PER_BIT=4. Inputs are driven and outputs sampled on the falling
// clock edge, away from the active rising edge.
module tb_uart_tx_param;

  localparam int C = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_;

  logic       en_s[4];
  logic       valid_s[4];
  logic [8:0] data_s[4];
  logic       ready_s[4];
  logic       txd_s[4];
  logic       busy_s[4];
  logic       done_s[4];

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_(rst_), .en(en_s[0]), .tx_valid(valid_s[0]), .tx_data(data_s[0][7:0]),
    .tx_ready(ready_s[0]), .txd(txd_s[0]), .busy(busy_s[0]), .done(done_s[0]));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_(rst_), .en(en_s[1]), .tx_valid(valid_s[1]), .tx_data(data_s[1][7:0]),
    .tx_ready(ready_s[1]), .txd(txd_s[1]), .busy(busy_s[1]), .done(done_s[1]));
  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_(rst_), .en(en_s[2]), .tx_valid(valid_s[2]), .tx_data(data_s[2][7:0]),
    .tx_ready(ready_s[2]), .txd(txd_s[2]), .busy(busy_s[2]), .done(done_s[2]));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst_(rst_), .en(en_s[3]), .tx_valid(valid_s[3]), .tx_data(data_s[3][4:0]),
    .tx_ready(ready_s[3]), .txd(txd_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  int   n_checks = 0;
  int   n_pass   = 0;
  logic tr_q[$];
  logic [0:0] exp_q[$];
  logic saw_ready;
  logic saw_idle;

  // expected per-cycle txd; bits[0] is the start bit, wide_bit gets extra cycles
  task automatic build_exp(input logic [15:0] bits, input int nbits, input int wide_bit,
                           input int extra);
    exp_q.delete();
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < C + ((k == wide_bit) ? extra : 0); c++) exp_q.push_back(bits[k]);
    end
  endtask

  // driver: present a word and return on the first start-bit cycle
  task automatic send(input int i, input logic [8:0] d);
    int w;
    valid_s[i] = 1'b1;
    data_s[i]  = d;
    w = 0;
    while (!ready_s[i] && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    valid_s[i] = 1'b0;
  endtask

  // record txd every cycle until done; optional en drop and busy-time valid pulse
  task automatic capture(input int i, input int drop_at, input int drop_len, input int pulse_at);
    int  n;
    logic fin;
    tr_q.delete();
    saw_ready = 1'b0;
    saw_idle  = 1'b0;
    n   = 0;
    fin = 1'b0;
    while (!fin && n < 400) begin
      tr_q.push_back(txd_s[i]);
      if (ready_s[i]) saw_ready = 1'b1;
      if (!busy_s[i]) saw_idle = 1'b1;
      if (done_s[i]) begin
        fin = 1'b1;
      end else begin
        if (n == drop_at) en_s[i] = 1'b0;
        if (n == drop_at + drop_len) en_s[i] = 1'b1;
        if (n == pulse_at) begin
          valid_s[i] = 1'b1;
          data_s[i]  = 9'h1FF;
        end
        if (n == pulse_at + 1) valid_s[i] = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    if (!fin) tr_q.delete();
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_s[i] = 1'b1; valid_s[i] = 1'b0; data_s[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (txd_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || ready_s[i] !== 1'b1 || done_s[i] !== 1'b0)
        $display("FAIL reset_state inst%0d: txd=%b busy=%b ready=%b done=%b, want 1 0 1 0",
                 i, txd_s[i], busy_s[i], ready_s[i], done_s[i]);
      else n_pass++;
    end
    rst_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_en_idle();
    en_s[0] = 1'b0; valid_s[0] = 1'b1; data_s[0] = 9'h055;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (ready_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || txd_s[0] !== 1'b1)
        $display("FAIL en_low_idle cyc%0d: ready=%b busy=%b txd=%b, want 0 0 1",
                 k, ready_s[0], busy_s[0], txd_s[0]);
      else n_pass++;
    end
    valid_s[0] = 1'b0;
    en_s[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || txd_s[0] !== 1'b1)
      $display("FAIL en_low_no_capture: ready=%b busy=%b txd=%b, want 1 0 1",
               ready_s[0], busy_s[0], txd_s[0]);
    else n_pass++;
  endtask

  task automatic test_basic();
    send(0, 9'h0A5);
    capture(0, -1, 0, -1);
    build_exp({1'b1, 8'hA5, 1'b0}, 10, -1, 0);
    n_checks++;
    if (tr_q.size() != 40) $display("FAIL basic_len: got %0d want 40", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL basic_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    n_checks++;
    if (saw_ready !== 1'b0 || saw_idle !== 1'b0)
      $display("FAIL basic_ready_busy: ready_seen=%b idle_seen=%b want 0 0", saw_ready, saw_idle);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ready_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || txd_s[0] !== 1'b1 || done_s[0] !== 1'b0)
      $display("FAIL basic_after_done: ready=%b busy=%b txd=%b done=%b want 1 0 1 0",
               ready_s[0], busy_s[0], txd_s[0], done_s[0]);
    else n_pass++;
  endtask

  task automatic test_parity();
    send(1, 9'h007);
    capture(1, -1, 0, -1);
    build_exp({1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 0);
    n_checks++;
    if (tr_q.size() != 44) $display("FAIL even_len: got %0d want 44", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL even_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    send(2, 9'h007);
    capture(2, -1, 0, -1);
    build_exp({1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 0);
    n_checks++;
    if (tr_q.size() != 44) $display("FAIL odd_len: got %0d want 44", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL odd_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    send(3, 9'h01F);
    capture(3, -1, 0, -1);
    build_exp({2'b11, 5'h1F, 1'b0}, 8, -1, 0);
    n_checks++;
    if (tr_q.size() != 32) $display("FAIL b2b_first_len: got %0d want 32", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL b2b_first_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    valid_s[3] = 1'b1;
    data_s[3]  = 9'h000;
    @(negedge clk);
    n_checks++;
    if (ready_s[3] !== 1'b1 || txd_s[3] !== 1'b1 || busy_s[3] !== 1'b0)
      $display("FAIL b2b_gap: ready=%b txd=%b busy=%b want 1 1 0", ready_s[3], txd_s[3], busy_s[3]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (txd_s[3] !== 1'b0 || busy_s[3] !== 1'b1)
      $display("FAIL b2b_second_start: txd=%b busy=%b want 0 1", txd_s[3], busy_s[3]);
    else n_pass++;
    valid_s[3] = 1'b0;
    capture(3, -1, 0, -1);
    build_exp({2'b11, 5'h00, 1'b0}, 8, -1, 0);
    n_checks++;
    if (tr_q.size() != 32) $display("FAIL b2b_second_len: got %0d want 32", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL b2b_second_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_en_stretch();
    send(0, 9'h0C3);
    // cycle 17 lies inside frame bit 4 (data bit 3)
    capture(0, 17, 7, -1);
    build_exp({1'b1, 8'hC3, 1'b0}, 10, 4, 7);
    n_checks++;
    if (tr_q.size() != 47) $display("FAIL stretch_len: got %0d want 47", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL stretch_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send(0, 9'h05A);
    repeat (13) @(negedge clk);
    n_checks++;
    if (txd_s[0] !== 1'b0 || busy_s[0] !== 1'b1)
      $display("FAIL mid_pre_reset: txd=%b busy=%b want 0 1", txd_s[0], busy_s[0]);
    else n_pass++;
    rst_ = 1'b0;
    #1;
    n_checks++;
    if (txd_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || ready_s[0] !== 1'b1 || done_s[0] !== 1'b0)
      $display("FAIL mid_async_reset: txd=%b busy=%b ready=%b done=%b want 1 0 1 0",
               txd_s[0], busy_s[0], ready_s[0], done_s[0]);
    else n_pass++;
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    send(0, 9'h03C);
    capture(0, -1, 0, -1);
    build_exp({1'b1, 8'h3C, 1'b0}, 10, -1, 0);
    n_checks++;
    if (tr_q.size() != 40) $display("FAIL post_reset_len: got %0d want 40", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL post_reset_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    logic bad;
    send(0, 9'h081);
    capture(0, -1, 0, 10);
    build_exp({1'b1, 8'h81, 1'b0}, 10, -1, 0);
    n_checks++;
    if (tr_q.size() != 40) $display("FAIL ignore_len: got %0d want 40", tr_q.size());
    else n_pass++;
    for (int k = 0; k < tr_q.size() && k < exp_q.size(); k++) begin
      n_checks++;
      if (tr_q[k] !== exp_q[k]) $display("FAIL ignore_txd cyc%0d: got %b want %b", k, tr_q[k], exp_q[k]);
      else n_pass++;
    end
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy_s[0] !== 1'b0 || txd_s[0] !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) $display("FAIL ignore_no_second_frame: activity seen=%b want 0", bad);
    else n_pass++;
  endtask

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_en_idle();
    test_basic();
    test_parity();
    test_back_to_back();
    test_en_stretch();
    test_reset_mid();
    test_ignore_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that serialises one DATA_W-bit word per frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. It has an internal baud divider, so each bit lasts exactly CLKS_PER_BIT clocks. Words are accepted through a valid/ready handshake. It sits between a host-side byte source (FIFO or register) and the serial pin, and supersedes the fixed 8N1 transmitter.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; legal 1 or 2

Ports:
clk  in  1  clock
rst_  in  1  reset, asynchronous, active-low
en  in  1  global enable; low freezes all state
tx_valid  in  1  host presents a word
tx_data  in  DATA_W  word to send
tx_ready  out  1  block can accept a word
txd  out  1  serial line, idle high
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_ low): state=IDLE, txd=1, tx_ready=1, busy=0, done=0; baud and bit counters cleared; shift register cleared. Reset mid-frame aborts the frame immediately, and txd goes to 1 asynchronously.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, tx_ready=1, busy=0.
  - A handshake (tx_valid & tx_ready & en) captures tx_data into the shift register and moves to START.
  - On the next cycle txd=0, busy=1, tx_ready=0.
- Bit timing: a baud counter runs 0..CLKS_PER_BIT-1. Each bit holds txd for exactly CLKS_PER_BIT enabled cycles. Transitions occur when the counter reaches CLKS_PER_BIT-1.
- START: txd=0 for one bit time, then go to DATA.
- DATA:
  - txd = shift[0]; shift right at each bit end.
  - The bit counter counts DATA_W bits.
  - After the last data bit, go to PARITY if PARITY!=0, else to STOP.
- PARITY:
  - Even: txd = XOR of the captured word.
  - Odd: txd = inverted XOR.
  - Parity is computed from the word latched at acceptance, not from live tx_data.
  - Lasts one bit time.
- STOP:
  - txd=1 for STOP_BITS bit times.
  - In the final cycle of the last stop bit, done=1 for exactly one cycle and the state moves to IDLE.
- Frame length: CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles from the first txd=0 cycle to the done cycle inclusive.
- Back-to-back frames:
  - tx_ready returns to 1 in the cycle after done.
  - That IDLE cycle has txd=1.
  - Minimum inter-frame gap is therefore 1 clk beyond the stop bits.
- tx_valid and tx_data are ignored while busy. No queuing.
- en low:
  - State, counters, shift register and txd hold their values.
  - tx_ready is driven 0, so no acceptance occurs.
  - done is not asserted.
  - Bit timing resumes exactly where it stopped when en returns high; bit widths stretch by the number of disabled cycles.
- en low and tx_valid high in IDLE: no capture; the word must be re-presented.
- Illegal parameter values: out of scope; the simulation asserts an error at elaboration.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send 0xA5.
   -> txd bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clks.
   -> done pulses 40 clks after the first low cycle (inclusive).
   -> tx_ready=0 throughout the frame.
2. PARITY=1, send 0x07 -> parity bit 1. PARITY=2, send 0x07 -> parity bit 0. Frame length 44 clks at CLKS_PER_BIT=4.
3. STOP_BITS=2, DATA_W=5, send 0x1F.
   -> 0,1,1,1,1,1,1,1.
   -> done after 8 bit times.
   -> tx_valid held high with 0x00 on the next word: the second frame's start bit begins 2 clks after done.
4. Mid-frame, drop en for 7 cycles during data bit 3.
   -> txd frozen.
   -> bit 3 lasts CLKS_PER_BIT+7 clks.
   -> remaining bits nominal, with the correct data sequence.
5. Assert rst_ low during data bit 2.
   -> txd=1, busy=0, tx_ready=1 asynchronously.
   -> After release, a new 0x3C frame transmits correctly with no residue.
6. Pulse tx_valid with 0xFF while busy.
   -> Ignored; the current frame completes unchanged and no second frame starts.
